// File: rtl/instr_feeder.sv
// instr_feeder
//   Buffered instruction fetch path in front of the 8-bit CPU core. A loader
//   pushes W-bit instruction words over a valid/ready handshake into a
//   DEPTH-entry FIFO. An IDLE/RUN/DONE issue FSM pops one word per cycle onto
//   the core's inp bus while run=1 and hold=0. Popping a word tagged as last
//   ends the program (DONE) until run drops.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_word    : instruction word offered by the loader
//   in_last    : in_word is the final instruction of the program
//   in_valid   : loader offers in_word/in_last
//   in_ready   : feeder can accept (== !full)
//   run        : enable issuing
//   hold       : core stall, suppresses issue while high
//   inp        : registered instruction presented to the core
//   issue      : one-cycle strobe, inp carries a newly issued word
//   done       : the last-tagged word has been issued
//   count      : FIFO occupancy 0..DEPTH
//   empty/full : occupancy == 0 / == DEPTH
//   issued_cnt : words issued since reset (wraps)
module instr_feeder #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [W-1:0]                   in_word,
  input  logic                           in_last,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           run,
  input  logic                           hold,
  output logic [W-1:0]                   inp,
  output logic                           issue,
  output logic                           done,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full,
  output logic [15:0]                    issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic [W-1:0]    inp_q, inp_d;
  logic            issue_q, issue_d;
  logic            done_q, done_d;
  logic [15:0]     issued_cnt_q, issued_cnt_d;
  logic [W:0]      mem_q [DEPTH];

  logic            push_s;
  logic            pop_s;
  logic [W:0]      head_s;

  // Storage array: entries hold {last, word}; no reset needed since reads
  // are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wr_ptr_q] <= {in_last, in_word};
    end
  end

  // Issue FSM next state and pop decision.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_RUN;
        else     state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (!hold && !empty_q) begin
          pop_s = 1'b1;
          if (head_s[W]) state_d = ST_DONE;
          else           state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!run) state_d = ST_IDLE;
        else      state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and issue datapath next values.
  always_comb begin
    push_s       = in_valid && !full_q;
    head_s       = mem_q[rd_ptr_q];
    wr_ptr_d     = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d     = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d      = (count_d == CW'(0));
    full_d       = (count_d == CW'(DEPTH));
    inp_d        = pop_s ? head_s[W-1:0] : inp_q;
    issue_d      = pop_s;
    issued_cnt_d = pop_s ? (issued_cnt_q + 16'd1) : issued_cnt_q;
    done_d       = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      inp_q        <= '0;
      issue_q      <= 1'b0;
      done_q       <= 1'b0;
      issued_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      inp_q        <= inp_d;
      issue_q      <= issue_d;
      done_q       <= done_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // in_ready depends only on registered full, never on in_valid.
  assign in_ready   = !full_q;
  assign inp        = inp_q;
  assign issue      = issue_q;
  assign done       = done_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a vector table for the basic program
// and full-FIFO back-pressure, followed by hand-written sequences for
// streaming with pointer wrap, hold, mid-run reset and issued_cnt wrap.
module tb_instr_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] in_word;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic        run;
  logic        hold;
  logic [19:0] inp;
  logic        issue;
  logic        done;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic [15:0] issued_cnt;

  int checks   = 0;
  int failures = 0;

  instr_feeder #(.DEPTH(8), .W(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_word    (in_word),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .run        (run),
    .hold       (hold),
    .inp        (inp),
    .issue      (issue),
    .done       (done),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [19:0] word;
    logic        last;
    logic        valid;
    logic        run;
    logic        hold;
    logic [19:0] e_inp;
    logic        e_issue;
    logic        e_done;
    logic [3:0]  e_count;
    logic        e_full;
    logic        e_empty;
    logic        e_ready;
    logic [15:0] e_icnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [19:0] w, logic l, logic v,
                              logic rn, logic h, logic [19:0] ei, logic eis,
                              logic ed, logic [3:0] ec, logic ef, logic ee,
                              logic er, logic [15:0] eic);
    vec_t t;
    t.rst_n = r;  t.word = w;  t.last = l;  t.valid = v;  t.run = rn;
    t.hold = h;   t.e_inp = ei; t.e_issue = eis; t.e_done = ed;
    t.e_count = ec; t.e_full = ef; t.e_empty = ee; t.e_ready = er;
    t.e_icnt = eic;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic [19:0] w, logic l, logic v, logic rn, logic h);
    rst_n = r; in_word = w; in_last = l; in_valid = v; run = rn; hold = h;
  endtask

  task automatic do_reset();
    drive(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(string p);
    chk({p, "_inp"},   32'(inp), 32'h0);
    chk({p, "_issue"}, 32'(issue), 32'h0);
    chk({p, "_done"},  32'(done), 32'h0);
    chk({p, "_count"}, 32'(count), 32'h0);
    chk({p, "_empty"}, 32'(empty), 32'h1);
    chk({p, "_full"},  32'(full), 32'h0);
    chk({p, "_ready"}, 32'(in_ready), 32'h1);
    chk({p, "_icnt"},  32'(issued_cnt), 32'h0);
  endtask

  logic [19:0] sb[$];
  logic [19:0] exp_w;

  initial begin
    drive(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic 3-word program, then fill to full and back-pressure the 9th word.
    vecs.push_back(mk(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 20'h1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 20'h2, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 20'h3, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 16'd0));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 16'd1));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h2, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 16'd2));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 16'd3));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 16'd3));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd3));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b1, 20'h10 + 20'(i), 1'b0, 1'b1, 1'b0, 1'b0, 20'h3, 1'b0, 1'b0,
                        4'(i + 1), (i == 7), 1'b0, (i != 7), 16'd3));
    end
    vecs.push_back(mk(1'b1, 20'h99, 1'b0, 1'b1, 1'b0, 1'b0, 20'h3, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd3));
    vecs.push_back(mk(1'b1, 20'h99, 1'b0, 1'b1, 1'b1, 1'b0, 20'h3, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd3));
    vecs.push_back(mk(1'b1, 20'h99, 1'b0, 1'b1, 1'b1, 1'b0, 20'h10, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 16'd4));
    vecs.push_back(mk(1'b1, 20'h99, 1'b0, 1'b1, 1'b0, 1'b0, 20'h10, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd4));
    vecs.push_back(mk(1'b1, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h10, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd4));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].word, vecs[i].last, vecs[i].valid, vecs[i].run, vecs[i].hold);
      step();
      chk($sformatf("v%0d_inp", i),   32'(inp),        32'(vecs[i].e_inp));
      chk($sformatf("v%0d_issue", i), 32'(issue),      32'(vecs[i].e_issue));
      chk($sformatf("v%0d_done", i),  32'(done),       32'(vecs[i].e_done));
      chk($sformatf("v%0d_count", i), 32'(count),      32'(vecs[i].e_count));
      chk($sformatf("v%0d_full", i),  32'(full),       32'(vecs[i].e_full));
      chk($sformatf("v%0d_empty", i), 32'(empty),      32'(vecs[i].e_empty));
      chk($sformatf("v%0d_ready", i), 32'(in_ready),   32'(vecs[i].e_ready));
      chk($sformatf("v%0d_icnt", i),  32'(issued_cnt), 32'(vecs[i].e_icnt));
    end

    // Streaming: push and pop every cycle with two words in flight.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 20'h100 + 20'(k), 1'b0, 1'b1, 1'b0, 1'b0);
      sb.push_back(20'h100 + 20'(k));
      step();
    end
    drive(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("stream_pre_count", 32'(count), 32'd2);
    chk("stream_pre_issue", 32'(issue), 32'd0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 20'h102 + 20'(k), 1'b0, 1'b1, 1'b1, 1'b0);
      sb.push_back(20'h102 + 20'(k));
      step();
      exp_w = sb.pop_front();
      chk($sformatf("stream%0d_issue", k), 32'(issue), 32'd1);
      chk($sformatf("stream%0d_inp", k),   32'(inp),   32'(exp_w));
      chk($sformatf("stream%0d_count", k), 32'(count), 32'd2);
    end

    // Hold for two cycles: no issue, inp frozen, then resume in order.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      chk($sformatf("hold%0d_issue", k), 32'(issue), 32'd0);
      chk($sformatf("hold%0d_inp", k),   32'(inp),   32'(exp_w));
      chk($sformatf("hold%0d_count", k), 32'(count), 32'd2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      exp_w = sb.pop_front();
      chk($sformatf("resume%0d_issue", k), 32'(issue), 32'd1);
      chk($sformatf("resume%0d_inp", k),   32'(inp),   32'(exp_w));
    end
    step();
    chk("drain_issue", 32'(issue), 32'd0);
    chk("drain_inp",   32'(inp),   32'(exp_w));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_icnt",  32'(issued_cnt), 32'd22);

    // Mid-run reset with five words buffered (held off by hold).
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 20'h200 + 20'(k), 1'b0, 1'b1, 1'b1, 1'b1);
      step();
    end
    chk("prerst_count", 32'(count), 32'd5);
    drive(1'b0, 20'h2FF, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_reset_vals("midrst");
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("postrst%0d_issue", k), 32'(issue), 32'd0);
      chk($sformatf("postrst%0d_inp", k),   32'(inp),   32'd0);
      chk($sformatf("postrst%0d_count", k), 32'(count), 32'd0);
    end

    // issued_cnt wrap: one issue per cycle after the first edge.
    do_reset();
    drive(1'b1, 20'h300, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 65536; k++) begin
      step();
    end
    chk("wrap_pre_icnt",  32'(issued_cnt), 32'hFFFF);
    chk("wrap_pre_issue", 32'(issue),      32'd1);
    step();
    chk("wrap_icnt",  32'(issued_cnt), 32'h0000);
    chk("wrap_issue", 32'(issue),      32'd1);
    chk("wrap_inp",   32'(inp),        32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Upstream instruction feeder for the 8-bit little-endian CPU core (`Main`). It accepts 20-bit instruction words from a loader through a valid/ready handshake and buffers them in an 8-entry FIFO. It issues them one per cycle onto the core's `inp` bus, honouring run/hold controls and an end-of-program marker. It replaces ad-hoc per-line stimulus with a real buffered fetch path, so the core can be fed at full rate or stalled.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `W`, 20, instruction word width; matches the core's `inp`
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_word`  in  W  instruction word from loader
- `in_last`  in  1  marks `in_word` as final instruction of program
- `in_valid`  in  1  loader offers `in_word`/`in_last`
- `in_ready`  out  1  feeder can accept; equals `!full`
- `run`  in  1  enable issuing
- `hold`  in  1  core stall; no issue while high
- `inp`  out  W  instruction presented to core; registered
- `issue`  out  1  one-cycle strobe: `inp` changed to a new word this cycle
- `done`  out  1  final-tagged word has been issued
- `count`  out  4  FIFO occupancy 0..DEPTH
- `empty`, `full`  out  1  occupancy == 0 / == DEPTH
- `issued_cnt`  out  16  words issued since reset

## Operation
- Clock `clk`; reset `rst_n` is synchronous and active-low.
- FIFO stores {in_last, in_word} (W+1 bits). Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.
- Push when `in_valid && in_ready`. `in_ready = !full`, so a push into a full FIFO cannot occur. Words pushed while `in_ready=0` are ignored and the loader must hold them.
- Issue FSM states: IDLE, RUN, DONE.
  - IDLE: no issue. Go to RUN when `run=1` is sampled.
  - RUN: if `run=0`, go to IDLE with no issue this cycle. Else if `hold=0 && !empty`, pop the head: `inp` <= word, `issue` <= 1, `issued_cnt` += 1. If the popped word has last=1, go to DONE. Otherwise `issue` <= 0 and `inp` holds.
  - DONE: `done=1`, no issue, pushes still accepted. Go to IDLE when `run=0` is sampled; `done` clears on the same edge.
- Simultaneous push and pop in one cycle: both take effect and `count` is unchanged. A pop at count==DEPTH with a push in the same cycle is impossible because `in_ready=0`.
- No bypass: a word pushed into an empty FIFO is not issued in the same cycle.
- `issued_cnt` wraps from 0xFFFF to 0x0000.
- `inp` keeps the last issued word indefinitely (through hold, empty, IDLE, DONE) until the next issue or reset.

## Timing
- Reset values, applied at the first rising edge with `rst_n=0`: `inp=0`, `issue=0`, `done=0`, `count=0`, `issued_cnt=0`, state IDLE, pointers 0, `empty=1`, `full=0`, `in_ready=1`.
- A reset asserted mid-operation discards all FIFO contents and any pending last flag at that edge. Inputs in that cycle are ignored.
- Push latency: a word pushed at edge N can appear on `inp` with `issue=1` after edge N+1 at the earliest, if RUN, `hold=0`, and it is the head.
- Throughput: one issue per cycle while RUN, `hold=0`, and not empty.
- `hold` and `run` act in the cycle they are sampled. With `hold=1` at edge N, no pop occurs at N and `issue=0` after N.
- `count`, `empty`, `full`, `inp`, `issue`, `done`, `issued_cnt` are registered. `in_ready` is derived combinationally from registered `full` only, with no path from `in_valid`.

## Test plan
- Reset, then push 0x00001, 0x00002, 0x00003 (last on third) with `run=0`, then raise `run` -> `issue` high for exactly 3 consecutive cycles, `inp` shows 0x00001/0x00002/0x00003 in that order, `done=1` after the third issue, `issued_cnt=3`.
- Push 8 words with `run=0` -> `count=8`, `full=1`, `in_ready=0`. A 9th offered word stays unaccepted and `count` stays 8. Raise `run` for one pop -> `in_ready=1` and the 9th word is accepted next cycle.
- With RUN, continuous push and pop at 1 word/cycle over 20 words -> `count` stays constant, pointers wrap past DEPTH, and the issue order matches the push order.
- Pulse `hold=1` for 2 cycles mid-stream -> `issue=0` and `inp` stable for exactly those 2 cycles, and no word is lost or duplicated.
- Assert `rst_n=0` for one cycle with 5 words buffered in RUN -> all outputs return to their reset values, `count=0`, and the discarded words are never issued.
- Preload `issued_cnt` to 0xFFFF via 65535 issues (or force), then issue 1 more -> `issued_cnt` reads 0x0000.
